// File: rtl/mux2_arb_32b.sv
// mux2_arb_32b
// Two-requester round-robin arbiter sharing one W-bit output channel
// between sources A and B. The granted source drives the select of a 2:1
// datapath mux. The chosen word is captured into a one-entry output
// register with a valid/ready handshake. Saturating per-source transfer
// counters are kept for debug and performance readout.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   a_valid/a_data     source A request and word; a_ready = A accepted
//   b_valid/b_data     source B request and word; b_ready = B accepted
//   z_valid/z_data     registered output word and its valid flag
//   z_src              registered source of z_data (0=A, 1=B)
//   z_ready            consumer accepts z_data when z_valid & z_ready
//   s                  combinational mux select for the current grant
//   cnt_a/cnt_b        saturating counts of accepted A / B words
module mux2_arb_32b #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [W-1:0]     a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [W-1:0]     b_data,
  output logic             b_ready,
  output logic             z_valid,
  output logic [W-1:0]     z_data,
  output logic             z_src,
  input  logic             z_ready,
  output logic             s,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_t;

  stage_state_t state_q, state_d;

  logic last;
  logic sel;
  logic can_accept;
  logic xfer_a;
  logic xfer_b;
  logic xfer;

  // The output register can take a new word when it is empty or is being
  // drained this very cycle, which gives one word per cycle throughput.
  assign z_valid    = (state_q == FULL);
  assign can_accept = !z_valid || z_ready;

  // Round-robin grant: a lone requester always wins; under contention the
  // source that did not win the last transfer goes next. With no request
  // the select rests on the last winner so the mux does not toggle.
  always_comb begin
    sel = last;
    if (a_valid && b_valid) begin
      sel = ~last;
    end else if (a_valid) begin
      sel = 1'b0;
    end else if (b_valid) begin
      sel = 1'b1;
    end
  end

  // Ready goes only to the granted source, so both can never be high
  // together. Readies are forced low during reset because the empty stage
  // would otherwise advertise space while the registers are being cleared.
  assign s       = sel;
  assign a_ready = rst_n && can_accept && a_valid && !sel;
  assign b_ready = rst_n && can_accept && b_valid &&  sel;
  assign xfer_a  = a_valid && a_ready;
  assign xfer_b  = b_valid && b_ready;
  assign xfer    = xfer_a || xfer_b;

  // Output stage next state: a transfer always leaves the stage full (it
  // refills while draining); a drain without a refill empties it; a stall
  // keeps it full.
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = FULL;
    end else if (z_ready) begin
      state_d = EMPTY;
    end
  end

  // Output stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath capture and round-robin history. The last-winner bit only
  // moves on a real transfer, so idle and stalled cycles do not disturb
  // fairness. Resetting last to B makes A win the first contention.
  // Data and source are left untouched on drain so they hold their value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_data <= '0;
      z_src  <= 1'b0;
      last   <= 1'b1;
    end else if (xfer) begin
      z_data <= sel ? b_data : a_data;
      z_src  <= sel;
      last   <= sel;
    end
  end

  // Per-source transfer counters that stick at all-ones instead of
  // wrapping, so a long run never reads back as a small number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (xfer_a && (cnt_a != {CNT_W{1'b1}})) begin
        cnt_a <= cnt_a + CNT_W'(1);
      end
      if (xfer_b && (cnt_b != {CNT_W{1'b1}})) begin
        cnt_b <= cnt_b + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux2_arb_32b.sv
// tb_mux2_arb_32b
// Directed bench for mux2_arb_32b. A default instance (CNT_W=16) and a
// narrow-counter instance (CNT_W=4) share the same stimulus. Inputs are
// driven on the falling edge; combinational outputs are checked 1ns later,
// registered outputs on the falling edge after the capturing rising edge.
module tb_mux2_arb_32b;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [31:0] a_data;
  logic        b_valid;
  logic [31:0] b_data;
  logic        z_ready;

  logic        a_ready, b_ready, z_valid, z_src, s;
  logic [31:0] z_data;
  logic [15:0] cnt_a, cnt_b;

  logic        a_ready4, b_ready4, z_valid4, z_src4, s4;
  logic [31:0] z_data4;
  logic [3:0]  cnt_a4, cnt_b4;

  int vec;
  int miss;

  mux2_arb_32b #(.W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .z_valid(z_valid), .z_data(z_data), .z_src(z_src), .z_ready(z_ready),
    .s(s), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  mux2_arb_32b #(.W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready4),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready4),
    .z_valid(z_valid4), .z_data(z_data4), .z_src(z_src4), .z_ready(z_ready),
    .s(s4), .cnt_a(cnt_a4), .cnt_b(cnt_b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive everything idle, hold reset across one rising edge, release on
  // a falling edge. Leaves the bench aligned to a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = '0;
    b_data  = '0;
    z_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = 32'h12345678;
    b_data  = 32'h87654321;
    z_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vec++; if (z_valid !== 1'b0) begin miss++; $display("[TB] FAIL rst_z_valid got %b want 0", z_valid); end
    vec++; if (z_data !== 32'h0) begin miss++; $display("[TB] FAIL rst_z_data got %h want 00000000", z_data); end
    vec++; if (z_src !== 1'b0) begin miss++; $display("[TB] FAIL rst_z_src got %b want 0", z_src); end
    vec++; if (cnt_a !== 16'd0) begin miss++; $display("[TB] FAIL rst_cnt_a got %0d want 0", cnt_a); end
    vec++; if (cnt_b !== 16'd0) begin miss++; $display("[TB] FAIL rst_cnt_b got %0d want 0", cnt_b); end
    vec++; if (a_ready !== 1'b0) begin miss++; $display("[TB] FAIL rst_a_ready got %b want 0", a_ready); end
    vec++; if (b_ready !== 1'b0) begin miss++; $display("[TB] FAIL rst_b_ready got %b want 0", b_ready); end
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic test_single_a();
    do_reset();
    a_valid = 1'b1;
    a_data  = 32'h22222222;
    z_ready = 1'b1;
    #1;
    vec++; if (a_ready !== 1'b1) begin miss++; $display("[TB] FAIL single_a_ready got %b want 1", a_ready); end
    vec++; if (s !== 1'b0) begin miss++; $display("[TB] FAIL single_s got %b want 0", s); end
    vec++; if (b_ready !== 1'b0) begin miss++; $display("[TB] FAIL single_b_ready got %b want 0", b_ready); end
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    vec++; if (z_valid !== 1'b1) begin miss++; $display("[TB] FAIL single_z_valid got %b want 1", z_valid); end
    vec++; if (z_data !== 32'h22222222) begin miss++; $display("[TB] FAIL single_z_data got %h want 22222222", z_data); end
    vec++; if (z_src !== 1'b0) begin miss++; $display("[TB] FAIL single_z_src got %b want 0", z_src); end
    vec++; if (cnt_a !== 16'd1) begin miss++; $display("[TB] FAIL single_cnt_a got %0d want 1", cnt_a); end
    @(posedge clk);
    @(negedge clk);
    vec++; if (z_valid !== 1'b0) begin miss++; $display("[TB] FAIL drain_z_valid got %b want 0", z_valid); end
    vec++; if (z_data !== 32'h22222222) begin miss++; $display("[TB] FAIL drain_z_data_hold got %h want 22222222", z_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data;
    logic        exp_src;
    do_reset();
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = 32'hffffffff;
    b_data  = 32'heeeeeeee;
    z_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_src  = (i % 2 == 1);
      exp_data = exp_src ? 32'heeeeeeee : 32'hffffffff;
      #1;
      vec++; if (s !== exp_src) begin miss++; $display("[TB] FAIL b2b_s[%0d] got %b want %b", i, s, exp_src); end
      @(posedge clk);
      @(negedge clk);
      vec++; if (z_valid !== 1'b1) begin miss++; $display("[TB] FAIL b2b_z_valid[%0d] got %b want 1", i, z_valid); end
      vec++; if (z_src !== exp_src) begin miss++; $display("[TB] FAIL b2b_z_src[%0d] got %b want %b", i, z_src, exp_src); end
      vec++; if (z_data !== exp_data) begin miss++; $display("[TB] FAIL b2b_z_data[%0d] got %h want %h", i, z_data, exp_data); end
    end
    vec++; if (cnt_a !== 16'd2) begin miss++; $display("[TB] FAIL b2b_cnt_a got %0d want 2", cnt_a); end
    vec++; if (cnt_b !== 16'd2) begin miss++; $display("[TB] FAIL b2b_cnt_b got %0d want 2", cnt_b); end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    a_valid = 1'b1;
    a_data  = 32'h00001111;
    z_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_data  = 32'h0000aaaa;
    b_valid = 1'b1;
    b_data  = 32'h0000bbbb;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec++; if (a_ready !== 1'b0) begin miss++; $display("[TB] FAIL stall_a_ready[%0d] got %b want 0", i, a_ready); end
      vec++; if (b_ready !== 1'b0) begin miss++; $display("[TB] FAIL stall_b_ready[%0d] got %b want 0", i, b_ready); end
      vec++; if (z_data !== 32'h00001111) begin miss++; $display("[TB] FAIL stall_z_data[%0d] got %h want 00001111", i, z_data); end
      vec++; if (z_valid !== 1'b1) begin miss++; $display("[TB] FAIL stall_z_valid[%0d] got %b want 1", i, z_valid); end
      @(posedge clk);
      @(negedge clk);
    end
    vec++; if (z_data !== 32'h00001111) begin miss++; $display("[TB] FAIL stall_end_z_data got %h want 00001111", z_data); end
    vec++; if (cnt_a !== 16'd1) begin miss++; $display("[TB] FAIL stall_cnt_a got %0d want 1", cnt_a); end
    z_ready = 1'b1;
    #1;
    vec++; if (s !== 1'b1) begin miss++; $display("[TB] FAIL unstall_s got %b want 1", s); end
    vec++; if (b_ready !== 1'b1) begin miss++; $display("[TB] FAIL unstall_b_ready got %b want 1", b_ready); end
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    vec++; if (z_src !== 1'b1) begin miss++; $display("[TB] FAIL unstall_z_src got %b want 1", z_src); end
    vec++; if (z_data !== 32'h0000bbbb) begin miss++; $display("[TB] FAIL unstall_z_data got %h want 0000bbbb", z_data); end
  endtask

  task automatic test_only_b();
    do_reset();
    b_valid = 1'b1;
    b_data  = 32'h99998765;
    z_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vec++; if (s !== 1'b1) begin miss++; $display("[TB] FAIL onlyb_s[%0d] got %b want 1", i, s); end
      @(posedge clk);
      @(negedge clk);
      vec++; if (z_src !== 1'b1) begin miss++; $display("[TB] FAIL onlyb_z_src[%0d] got %b want 1", i, z_src); end
    end
    vec++; if (z_data !== 32'h99998765) begin miss++; $display("[TB] FAIL onlyb_z_data got %h want 99998765", z_data); end
    vec++; if (cnt_b !== 16'd4) begin miss++; $display("[TB] FAIL onlyb_cnt_b got %0d want 4", cnt_b); end
    vec++; if (cnt_a !== 16'd0) begin miss++; $display("[TB] FAIL onlyb_cnt_a got %0d want 0", cnt_a); end
    a_valid = 1'b1;
    a_data  = 32'h0000000a;
    #1;
    vec++; if (s !== 1'b0) begin miss++; $display("[TB] FAIL onlyb_then_both_s got %b want 0", s); end
    vec++; if (a_ready !== 1'b1) begin miss++; $display("[TB] FAIL onlyb_then_both_a_ready got %b want 1", a_ready); end
    @(posedge clk);
    @(negedge clk);
    vec++; if (z_src !== 1'b0) begin miss++; $display("[TB] FAIL onlyb_then_both_z_src got %b want 0", z_src); end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    a_valid = 1'b1;
    z_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_data = 32'h0000_0100 + i;
      @(posedge clk);
      @(negedge clk);
      if (i == 13) begin
        vec++; if (cnt_a4 !== 4'd14) begin miss++; $display("[TB] FAIL sat_cnt4_at14 got %0d want 14", cnt_a4); end
      end
      if (i == 14) begin
        vec++; if (cnt_a4 !== 4'd15) begin miss++; $display("[TB] FAIL sat_cnt4_at15 got %0d want 15", cnt_a4); end
      end
      if (i == 15) begin
        vec++; if (cnt_a4 !== 4'd15) begin miss++; $display("[TB] FAIL sat_cnt4_at16 got %0d want 15", cnt_a4); end
      end
    end
    vec++; if (cnt_a4 !== 4'd15) begin miss++; $display("[TB] FAIL sat_cnt4_final got %0d want 15", cnt_a4); end
    vec++; if (cnt_a !== 16'd20) begin miss++; $display("[TB] FAIL sat_cnt16_final got %0d want 20", cnt_a); end
    vec++; if (z_data4 !== 32'h00000113) begin miss++; $display("[TB] FAIL sat_z_data4 got %h want 00000113", z_data4); end
    a_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = 32'h0a0a0a0a;
    b_data  = 32'h0b0b0b0b;
    z_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    vec++; if (z_valid !== 1'b1) begin miss++; $display("[TB] FAIL midrst_pre_z_valid got %b want 1", z_valid); end
    vec++; if (cnt_a !== 16'd2) begin miss++; $display("[TB] FAIL midrst_pre_cnt_a got %0d want 2", cnt_a); end
    #2;
    rst_n = 1'b0;
    #1;
    vec++; if (z_valid !== 1'b0) begin miss++; $display("[TB] FAIL midrst_z_valid got %b want 0", z_valid); end
    vec++; if (cnt_a !== 16'd0) begin miss++; $display("[TB] FAIL midrst_cnt_a got %0d want 0", cnt_a); end
    vec++; if (cnt_b !== 16'd0) begin miss++; $display("[TB] FAIL midrst_cnt_b got %0d want 0", cnt_b); end
    vec++; if (z_data !== 32'h0) begin miss++; $display("[TB] FAIL midrst_z_data got %h want 00000000", z_data); end
    vec++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin miss++; $display("[TB] FAIL midrst_ready got %b%b want 00", a_ready, b_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vec++; if (s !== 1'b0) begin miss++; $display("[TB] FAIL postrst_s got %b want 0", s); end
    vec++; if (a_ready !== 1'b1) begin miss++; $display("[TB] FAIL postrst_a_ready got %b want 1", a_ready); end
    @(posedge clk);
    @(negedge clk);
    vec++; if (z_src !== 1'b0) begin miss++; $display("[TB] FAIL postrst_z_src got %b want 0", z_src); end
    vec++; if (z_data !== 32'h0a0a0a0a) begin miss++; $display("[TB] FAIL postrst_z_data got %h want 0a0a0a0a", z_data); end
    vec++; if (cnt_a !== 16'd1) begin miss++; $display("[TB] FAIL postrst_cnt_a got %0d want 1", cnt_a); end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    vec     = 0;
    miss    = 0;
    rst_n   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = '0;
    b_data  = '0;
    z_ready = 1'b0;
    test_reset();
    test_single_a();
    test_back_to_back();
    test_stall();
    test_only_b();
    test_saturation();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/mux2_arb_32b.md
Name: mux2_arb_32b

Overview:
- Two-requester round-robin arbiter that shares one W-bit output channel between sources A and B.
- Drives the select of the 2:1 32-bit datapath mux (s=0 picks A, s=1 picks B) and registers the chosen word into a one-entry output stage with valid/ready handshake.
- Keeps saturating per-source transfer counters for debug and performance readout.
- Sits between two producer units (e.g. ALU result and load data) and a single shared write-back/bus consumer.

Parameters:
W, 32, data width of each source and of the output.
CNT_W, 16, width of the per-source saturating grant counters.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
a_valid  input  1  source A has a word
a_data  input  W  source A word
a_ready  output  1  A word accepted this cycle when a_valid&a_ready
b_valid  input  1  source B has a word
b_data  input  W  source B word
b_ready  output  1  B word accepted this cycle when b_valid&b_ready
z_valid  output  1  output register holds a word
z_data  output  W  output word (registered)
z_src  output  1  source of z_data: 0=A, 1=B (registered)
z_ready  input  1  consumer accepts z_data when z_valid&z_ready
s  output  1  combinational mux select for the current grant
cnt_a  output  CNT_W  saturating count of accepted A words
cnt_b  output  CNT_W  saturating count of accepted B words

Behaviour:
- Reset (async, rst_n=0):
  - z_valid=0, z_data=0, z_src=0, cnt_a=0, cnt_b=0.
  - last=1, so A wins the first contention.
  - a_ready/b_ready low while rst_n=0.
- Output stage state: EMPTY (z_valid=0) or FULL (z_valid=1).
- can_accept = !z_valid | z_ready. The stage refills in the same cycle it drains, giving full throughput.
- Grant (combinational):
  - Only a_valid: grant A.
  - Only b_valid: grant B.
  - Both: grant the source not equal to last.
  - Neither: no grant; s holds last.
- s = granted source (0=A, 1=B). a_ready = can_accept & grant A. b_ready = can_accept & grant B. Ready is never asserted to both in the same cycle.
- Transfer on edge when (a_valid&a_ready) or (b_valid&b_ready):
  - z_data <= selected data, z_src <= s, z_valid <= 1, last <= s.
  - The corresponding counter increments, saturating at 2^CNT_W-1 with no wrap.
- z_valid&z_ready with no new transfer: z_valid <= 0. z_data and z_src hold their last values.
- FULL and z_ready=0: no ready asserted. z_data, z_src and z_valid are held stable until accepted, with no change while stalled.
- last updates only on a transfer, never on idle or stall cycles, so fairness is preserved across stalls.
- Latency: a word accepted at edge N appears on z_data/z_valid after edge N (one cycle).
- Requesters may drop valid without a handshake. This is legal and the arbiter holds no grant lock.
- Reset asserted mid-transfer: the output word is discarded and counters clear. After release, the first contention goes to A.

Test Plan:
1. Reset then a_valid=1, a_data=32'h22222222, z_ready=1 -> a_ready=1, s=0. Next cycle z_valid=1, z_data=32'h22222222, z_src=0, cnt_a=1.
2. Both valid continuously (a_data=32'hffffffff, b_data=32'heeeeeeee), z_ready=1 -> z_src alternates 0,1,0,1 starting with A. One word per cycle; cnt_a=cnt_b after an even number of transfers.
3. FULL with z_data=32'h00001111, z_ready=0 for 3 cycles, both valid -> a_ready=b_ready=0, z_data stable. When z_ready=1, the next grant goes to the source not in z_src.
4. Only b_valid, b_data=32'h99998765, for 4 cycles, z_ready=1 -> s=1, z_src=1, cnt_b=4, cnt_a=0. Then both valid -> A granted first.
5. CNT_W=4, A streams 20 words -> cnt_a saturates at 15 and stays there.
6. rst_n pulsed low mid-stream while z_valid=1 -> z_valid=0 and counters=0 immediately (asynchronous). After release with both valid, A wins.
